microwave_timer_ctrl: RTL and testbench
=======================================

Name: microwave_timer_ctrl

Overview:
Cook-time controller for the microwave. It accepts keypad digits and start/stop commands, then counts down once per 1 Hz tick. It drives the BCD digits sec_ones, sec_tens and min that feed the 7-segment decoder, plus the magnetron enable and the completion flag timer_done. It also owns the door interlock: the magnetron never runs with the door open.

Parameters:
DONE_HOLD, 3, number of tick_1hz pulses that timer_done stays asserted before the block returns to IDLE (1..15)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  reset; synchronous, active-low
tick_1hz  input  1  one-clk-wide pulse once per second (clock-enable, not a clock)
key_valid  input  1  one-clk pulse: key_digit is valid this cycle
key_digit  input  4  keypad digit, BCD
start  input  1  one-clk pulse: start or resume cooking
stop_clear  input  1  one-clk pulse: pause when cooking, otherwise clear
door_closed  input  1  1 = door shut
sec_ones  output  4  BCD seconds units, 0..9
sec_tens  output  4  BCD seconds tens, 0..5
min  output  4  BCD minutes, 0..9
mag_on  output  1  magnetron enable
timer_done  output  1  cook cycle complete

Behaviour:
- Reset: rst_n low at a clk edge forces state=IDLE, all digits=0, timer_done=0, internal hold counter=0. Reset overrides every other input in that cycle, including mid-cook.
- States: IDLE, SETTING, COOKING, PAUSED, DONE. Registered state.
- mag_on = (state==COOKING) & door_closed. This is combinational so a door opening kills mag_on in the same cycle. timer_done = (state==DONE), registered.
- Priority within one cycle: rst_n > stop_clear > door open > start > key_valid > tick_1hz.
- Digit entry, accepted only in IDLE/SETTING:
  - key_valid with key_digit<=9 shifts left: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
  - The key is rejected (no change) if key_digit>9 or if the current sec_ones>5, because that would put an illegal value in sec_tens.
  - An accepted key in IDLE moves to SETTING. Keys are ignored in COOKING, PAUSED and DONE.
- start:
  - From SETTING or PAUSED: goes to COOKING only if door_closed=1 and the count is nonzero. Otherwise it is ignored.
  - Ignored in IDLE, COOKING and DONE.
- stop_clear:
  - COOKING -> PAUSED, count held.
  - SETTING, PAUSED or DONE -> IDLE with all digits cleared.
  - IDLE: no effect.
- Door open (door_closed=0):
  - COOKING -> PAUSED, with no decrement even if tick_1hz is high in the same cycle.
  - DONE -> IDLE with digits cleared.
  - Other states are unaffected.
- Countdown happens in COOKING on tick_1hz when door_closed=1:
  - If sec_ones>0: sec_ones-1.
  - Else if sec_tens>0: sec_ones=9, sec_tens-1.
  - Else: sec_ones=9, sec_tens=5, min-1.
  - Borrow is BCD, never binary. Example: 1:00 -> 0:59.
- Completion: the tick that takes the count from 0:01 to 0:00 also moves state to DONE on the same edge. mag_on therefore drops in the cycle after that edge, and timer_done rises at that edge.
- DONE: digits stay 0:00. The hold counter increments on each tick_1hz. When it reaches DONE_HOLD the block goes to IDLE, timer_done=0 and the hold counter=0.
- Out-of-range digits cannot be produced internally. The max settable time is 9:59.

Test Plan:
- Reset mid-cook: cook from 0:05, assert rst_n=0 for 1 clk -> next edge state IDLE, digits 0:00:0, mag_on=0, timer_done=0.
- Entry and rejection:
  - Keys 1,3,0 -> min=1, sec_tens=3, sec_ones=0.
  - Key 12 -> no change.
  - From 0:07, key 2 -> rejected, since sec_ones 7>5.
- BCD borrow: set 1:00, start, one tick -> 0:59; 59 more ticks -> 0:00 and timer_done=1.
- Countdown and done: set 0:02, start, 2 ticks -> timer_done high for exactly 3 ticks (DONE_HOLD=3), mag_on low throughout, then IDLE.
- Door interlock: cooking at 0:10, drop door_closed coincident with a tick -> mag_on=0 same cycle, count stays 0:10, state PAUSED. start with the door still open -> ignored. Close door then start -> resumes from 0:10.
- Command collisions:
  - start and stop_clear in the same cycle while PAUSED -> IDLE, digits cleared.
  - start with count 0:00 in SETTING -> stays SETTING.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: BCD keypad entry, 1 Hz countdown, door interlock
// and a completion flag held for DONE_HOLD ticks.
module microwave_timer_ctrl #(
    parameter int unsigned DONE_HOLD = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min,
    output logic       mag_on,
    output logic       timer_done
);

    typedef enum logic [2:0] {IDLE, SETTING, COOKING, PAUSED, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(DONE_HOLD - 1);

    state_t     state, state_nxt;
    logic [3:0] ones_nxt, tens_nxt, min_nxt;
    logic [3:0] hold_cnt, hold_nxt;
    logic       count_zero, count_one, key_ok;

    assign count_zero = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign count_one  = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
    // A shifted-in key would move sec_ones into sec_tens, which must stay 0..5.
    assign key_ok     = (key_digit <= 4'd9) && (sec_ones <= 4'd5);

    assign mag_on = (state == COOKING) && door_closed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sec_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            min        <= 4'd0;
            hold_cnt   <= 4'd0;
            timer_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            sec_ones   <= ones_nxt;
            sec_tens   <= tens_nxt;
            min        <= min_nxt;
            hold_cnt   <= hold_nxt;
            timer_done <= (state_nxt == DONE);
        end
    end

    // Commands are resolved in strict priority: stop_clear, door open, start, key, tick.
    always_comb begin
        state_nxt = state;
        ones_nxt  = sec_ones;
        tens_nxt  = sec_tens;
        min_nxt   = min;
        hold_nxt  = hold_cnt;

        if (stop_clear) begin
            if (state == COOKING) begin
                state_nxt = PAUSED;
            end else if (state != IDLE) begin
                state_nxt = IDLE;
                ones_nxt  = 4'd0;
                tens_nxt  = 4'd0;
                min_nxt   = 4'd0;
                hold_nxt  = 4'd0;
            end
        end else if (!door_closed && (state == COOKING || state == DONE)) begin
            if (state == COOKING) begin
                state_nxt = PAUSED;
            end else begin
                state_nxt = IDLE;
                ones_nxt  = 4'd0;
                tens_nxt  = 4'd0;
                min_nxt   = 4'd0;
                hold_nxt  = 4'd0;
            end
        end else if (start && (state == SETTING || state == PAUSED)) begin
            if (door_closed && !count_zero) begin
                state_nxt = COOKING;
            end
        end else if (key_valid && (state == IDLE || state == SETTING)) begin
            if (key_ok) begin
                min_nxt   = sec_tens;
                tens_nxt  = sec_ones;
                ones_nxt  = key_digit;
                state_nxt = SETTING;
            end
        end else if (tick_1hz) begin
            if (state == COOKING) begin
                if (sec_ones != 4'd0) begin
                    ones_nxt = sec_ones - 4'd1;
                end else if (sec_tens != 4'd0) begin
                    ones_nxt = 4'd9;
                    tens_nxt = sec_tens - 4'd1;
                end else begin
                    ones_nxt = 4'd9;
                    tens_nxt = 4'd5;
                    min_nxt  = min - 4'd1;
                end
                if (count_one) begin
                    state_nxt = DONE;
                    hold_nxt  = 4'd0;
                end
            end else if (state == DONE) begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    hold_nxt  = 4'd0;
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed scoreboard bench for microwave_timer_ctrl; expectations are queued by the
// stimulus thread and compared by an independent monitor at the falling clock edge.
module tb_microwave_timer_ctrl;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       mag;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       stop_clear = 1'b0;
    logic       door_closed = 1'b1;
    logic [3:0] sec_ones, sec_tens, min;
    logic       mag_on, timer_done;

    obs_t  exp_q[$];
    string name_q[$];
    logic  check_req = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    obs_t  act_v, exp_v;
    string nm;

    microwave_timer_ctrl #(.DONE_HOLD(3)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .key_valid(key_valid),
        .key_digit(key_digit), .start(start), .stop_clear(stop_clear),
        .door_closed(door_closed), .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min(min), .mag_on(mag_on), .timer_done(timer_done)
    );

    always #5 clk = ~clk;

    // Monitor: pops the oldest expectation whenever the stimulus thread requests a sample.
    always @(negedge clk) begin
        if (check_req) begin
            act_v = {min, sec_tens, sec_ones, mag_on, timer_done};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL scoreboard_empty: sample requested with no expectation queued");
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got %0d:%0d%0d mag=%0b done=%0b, expected %0d:%0d%0d mag=%0b done=%0b",
                             nm, act_v.m, act_v.t, act_v.o, act_v.mag, act_v.done,
                             exp_v.m, exp_v.t, exp_v.o, exp_v.mag, exp_v.done);
                end
            end
            check_req = 1'b0;
        end
    end

    task automatic applyStimulus(input logic kv, input logic [3:0] kd, input logic st,
                                 input logic sc, input logic tk);
        key_valid  = kv;
        key_digit  = kd;
        start      = st;
        stop_clear = sc;
        tick_1hz   = tk;
    endtask

    task automatic clockCycle();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] m, input logic [3:0] t,
                               input logic [3:0] o, input logic mag, input logic done);
        exp_q.push_back({m, t, o, mag, done});
        name_q.push_back(name);
        check_req = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic pressKey(input logic [3:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
        clockCycle();
    endtask

    task automatic pressStart();
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        clockCycle();
    endtask

    task automatic pressStop();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        clockCycle();
    endtask

    task automatic tickOnce();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        clockCycle();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset_state", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Digit entry and rejection
        pressKey(4'd1); pressKey(4'd3); pressKey(4'd0);
        checkOutput("keys_1_3_0", 4'd1, 4'd3, 4'd0, 1'b0, 1'b0);
        pressKey(4'd12);
        checkOutput("key_12_rejected", 4'd1, 4'd3, 4'd0, 1'b0, 1'b0);
        pressStop();
        checkOutput("clear_from_setting", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        pressKey(4'd7);
        pressKey(4'd2);
        checkOutput("key_after_7_rejected", 4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
        pressStop();

        // Reset in the middle of cooking
        pressKey(4'd5);
        pressStart();
        checkOutput("cook_0_05", 4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
        tickOnce();
        checkOutput("cook_0_04", 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
        rst_n = 1'b0;
        clockCycle();
        rst_n = 1'b1;
        checkOutput("reset_mid_cook", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        pressStart();
        checkOutput("start_ignored_idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // BCD borrow from 1:00 down to completion
        pressKey(4'd1); pressKey(4'd0); pressKey(4'd0);
        pressStart();
        tickOnce();
        checkOutput("borrow_1_00_to_0_59", 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 49; i++) tickOnce();
        checkOutput("count_0_10", 4'd0, 4'd1, 4'd0, 1'b1, 1'b0);
        tickOnce();
        checkOutput("borrow_0_10_to_0_09", 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tickOnce();
        checkOutput("count_0_01", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        tickOnce();
        checkOutput("done_after_60", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        pressStop();
        checkOutput("clear_from_done", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Countdown from 0:02 and DONE hold of three ticks
        pressKey(4'd2);
        pressStart();
        tickOnce();
        checkOutput("cook_0_01", 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
        tickOnce();
        checkOutput("done_enter", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        tickOnce();
        checkOutput("done_hold_1", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        tickOnce();
        checkOutput("done_hold_2", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        tickOnce();
        checkOutput("done_hold_expired", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        pressKey(4'd4);
        checkOutput("idle_after_done_accepts_key", 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
        pressStop();

        // Door interlock
        pressKey(4'd1); pressKey(4'd0);
        pressStart();
        checkOutput("cook_0_10", 4'd0, 4'd1, 4'd0, 1'b1, 1'b0);
        door_closed = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("door_open_same_cycle", 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
        clockCycle();
        checkOutput("door_paused_no_decrement", 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
        pressStart();
        checkOutput("start_door_open_ignored", 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
        door_closed = 1'b1;
        checkOutput("door_closed_still_paused", 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
        pressStart();
        checkOutput("resume_0_10", 4'd0, 4'd1, 4'd0, 1'b1, 1'b0);
        tickOnce();
        checkOutput("resume_tick_0_09", 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);

        // Command collisions
        pressStop();
        checkOutput("stop_pauses", 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        clockCycle();
        checkOutput("start_stop_collision", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        pressKey(4'd0);
        pressStart();
        checkOutput("start_zero_ignored", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        pressKey(4'd3);
        checkOutput("still_setting_key_3", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
        pressStart();
        checkOutput("start_0_03", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
